// File: rtl/sha256_msg_schedule_if.sv
// sha256_msg_schedule_if: word-load handshake and round-stream outputs of the SHA-256 message schedule
interface sha256_msg_schedule_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        next_block;
   logic [31:0] w;
   logic [31:0] k;
   logic [6:0]  counter_iteration;
   logic        block_full;
   logic        round_valid;
   modport master (
      output in_valid, in_word, next_block,
      input  in_ready, w, k, counter_iteration, block_full, round_valid
   );
   modport slave (
      input  in_valid, in_word, next_block,
      output in_ready, w, k, counter_iteration, block_full, round_valid
   );
endinterface

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: captures a 16-word block and streams W[t]/K[t] for 64 rounds from a sliding window
module sha256_msg_schedule (
   input logic                   clk,
   input logic                   rst,
   sha256_msg_schedule_if.slave bus
);
   typedef enum logic [1:0] {LOAD, ROUND, FINAL, HOLD} state_t;
   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   state_t      state, state_nx;
   logic [3:0]  wr_cnt;
   logic [31:0] win [16];
   logic [31:0] w_new;
   logic [5:0]  k_idx;
   logic        accept;
   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction
   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction
   assign accept = bus.in_valid & bus.in_ready;
   assign k_idx  = bus.counter_iteration[5:0] + 6'd1;
   // window holds W[t..t+15] while counter_iteration is t, so this is W[t+16]
   assign w_new  = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
   always_comb begin
      state_nx = state;
      unique case (state)
         LOAD:  state_nx = (accept && wr_cnt == 4'd15) ? ROUND : LOAD;
         ROUND: state_nx = (bus.counter_iteration == 7'd63) ? FINAL : ROUND;
         FINAL: state_nx = HOLD;
         HOLD:  state_nx = bus.next_block ? LOAD : HOLD;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) state <= LOAD;
      else state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (accept) win[wr_cnt] <= bus.in_word;
      else if (state == ROUND) begin
         for (int i = 0; i < 15; i++) win[i] <= win[i+1];
         win[15] <= w_new;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_cnt                <= 4'd0;
         bus.in_ready          <= 1'b0;
         bus.w                 <= 32'd0;
         bus.k                 <= 32'd0;
         bus.counter_iteration <= 7'd0;
         bus.block_full        <= 1'b0;
         bus.round_valid       <= 1'b0;
      end else begin
         bus.in_ready <= state_nx == LOAD;
         unique case (state)
            LOAD: if (accept) begin
               wr_cnt <= wr_cnt + 4'd1;
               if (wr_cnt == 4'd15) begin
                  bus.w                 <= win[0];
                  bus.k                 <= K_TAB[0];
                  bus.counter_iteration <= 7'd0;
                  bus.block_full        <= 1'b1;
                  bus.round_valid       <= 1'b1;
               end
            end
            ROUND: if (bus.counter_iteration == 7'd63) begin
               bus.counter_iteration <= 7'd64;
               bus.round_valid       <= 1'b0;
            end else begin
               bus.w                 <= win[1];
               bus.k                 <= K_TAB[k_idx];
               bus.counter_iteration <= bus.counter_iteration + 7'd1;
            end
            FINAL: bus.counter_iteration <= 7'd65;
            HOLD: if (bus.next_block) begin
               bus.counter_iteration <= 7'd0;
               bus.block_full        <= 1'b0;
               wr_cnt                <= 4'd0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: random-gap block loads checked against a direct FIPS 180-4 schedule model
module tb_sha256_msg_schedule;
   typedef logic [31:0] blk_t [16];
   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   int          checks = 0;
   int          errors = 0;
   bit          is_abc;
   logic [31:0] exp_w [64];
   blk_t        abc, blk;
   sha256_msg_schedule_if bus();
   sha256_msg_schedule dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %08h expected %08h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic void model(input blk_t b);
      for (int t = 0; t < 64; t++)
         exp_w[t] = (t < 16) ? b[t] :
            (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10)) + exp_w[t-7] +
            (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3)) + exp_w[t-16];
   endfunction
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic load(input blk_t b, input int gap_pct);
      int idx = 0;
      int n = 0;
      bit acc;
      model(b);
      while (idx < 16 && n < 400) begin
         chk("load_ci", 32'(bus.counter_iteration), 0);
         chk("load_full", 32'(bus.block_full), 0);
         chk("load_rdy", 32'(bus.in_ready), 1);
         bus.in_valid = ($urandom_range(99) >= gap_pct);
         bus.in_word = bus.in_valid ? b[idx] : $urandom;
         acc = bus.in_valid && bus.in_ready;
         step;
         n++;
         if (acc) idx++;
      end
      bus.in_valid = 1'b0;
      if (idx < 16) chk("load_timeout", 32'(idx), 16);
   endtask
   task automatic run(input int stop_at, input bit pulse30);
      for (int t = 0; t < 64; t++) begin
         if (t == stop_at) return;
         chk("rnd_ci", 32'(bus.counter_iteration), 32'(t));
         chk("rnd_valid", 32'(bus.round_valid), 1);
         chk("rnd_full", 32'(bus.block_full), 1);
         chk("rnd_rdy", 32'(bus.in_ready), 0);
         chk($sformatf("w%0d", t), bus.w, exp_w[t]);
         chk($sformatf("k%0d", t), bus.k, KT[t]);
         if (is_abc && t == 16) chk("abc_w16", bus.w, 32'h61626380);
         if (is_abc && t == 17) chk("abc_w17", bus.w, 32'h000f0000);
         bus.in_valid = 1'($urandom_range(1));
         bus.in_word = $urandom;
         bus.next_block = pulse30 && t == 30;
         step;
         bus.next_block = 1'b0;
      end
      bus.in_valid = 1'b0;
      chk("fin_ci", 32'(bus.counter_iteration), 64);
      chk("fin_valid", 32'(bus.round_valid), 0);
      chk("fin_rdy", 32'(bus.in_ready), 0);
      bus.next_block = 1'b1;
      step;
      bus.next_block = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("hold_ci", 32'(bus.counter_iteration), 65);
         chk("hold_full", 32'(bus.block_full), 1);
         chk("hold_rdy", 32'(bus.in_ready), 0);
         chk("hold_valid", 32'(bus.round_valid), 0);
         chk("hold_w", bus.w, exp_w[63]);
         chk("hold_k", bus.k, KT[63]);
         bus.in_valid = 1'b1;
         bus.in_word = $urandom;
         step;
      end
      bus.in_valid = 1'b0;
   endtask
   task automatic release_blk(input bit with_valid);
      bus.next_block = 1'b1;
      bus.in_valid = with_valid;
      bus.in_word = 32'hdeadbeef;
      step;
      bus.next_block = 1'b0;
      bus.in_valid = 1'b0;
      chk("rel_ci", 32'(bus.counter_iteration), 0);
      chk("rel_full", 32'(bus.block_full), 0);
      chk("rel_rdy", 32'(bus.in_ready), 1);
      chk("rel_valid", 32'(bus.round_valid), 0);
   endtask
   task automatic chk_reset;
      chk("rst_ci", 32'(bus.counter_iteration), 0);
      chk("rst_w", bus.w, 0);
      chk("rst_k", bus.k, 0);
      chk("rst_full", 32'(bus.block_full), 0);
      chk("rst_valid", 32'(bus.round_valid), 0);
      chk("rst_rdy", 32'(bus.in_ready), 0);
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.in_word = 32'd0;
      bus.next_block = 1'b0;
      for (int i = 0; i < 16; i++) abc[i] = 32'd0;
      abc[0] = 32'h61626380;
      abc[15] = 32'h00000018;
      repeat (3) step;
      chk_reset();
      rst = 1'b1;
      step;
      chk("post_rst_rdy", 32'(bus.in_ready), 1);
      is_abc = 1'b1;
      load(abc, 0);
      run(64, 1'b1);
      release_blk(1'b1);
      load(abc, 40);
      run(64, 1'b0);
      release_blk(1'b0);
      is_abc = 1'b0;
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 16; i++) blk[i] = $urandom;
         load(blk, 30);
         run(64, 1'b1);
         release_blk(1'($urandom_range(1)));
      end
      is_abc = 1'b1;
      load(abc, 20);
      run(20, 1'b0);
      rst = 1'b0;
      step;
      chk_reset();
      rst = 1'b1;
      step;
      chk("rerst_rdy", 32'(bus.in_ready), 1);
      load(abc, 0);
      run(64, 1'b0);
      release_blk(1'b0);
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      is_abc = 1'b0;
      load(blk, 10);
      run(5, 1'b0);
      rst = 1'b0;
      step;
      chk_reset();
      rst = 1'b1;
      step;
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      load(blk, 25);
      run(64, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sha256_msg_schedule.md
SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

Interface
REQ-001 Parameters: none; word width fixed at 32 bits, block fixed at 16 words, round count fixed at 64.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  in_word carries a message word.
REQ-005 in_ready  output  1  block accepts a word this cycle.
REQ-006 in_word  input  32  message word, big-endian word order, word 0 first.
REQ-007 next_block  input  1  single-cycle pulse from the compression stage to release the current block.
REQ-008 w  output  32  schedule word W[t] for t = counter_iteration.
REQ-009 k  output  32  round constant K[t] for t = counter_iteration.
REQ-010 counter_iteration  output  7  round index, 0..65.
REQ-011 block_full  output  1  16 words captured; round stream active or finished.
REQ-012 round_valid  output  1  w/k valid for a round (counter_iteration 0..63).

Function
REQ-013 States SHALL be LOAD, ROUND, FINAL and HOLD.
REQ-014 LOAD: in_ready=1; each in_valid&in_ready cycle stores in_word at index wr_cnt (0..15), then wr_cnt increments.
REQ-015 When word 15 is accepted, the next cycle SHALL be ROUND with block_full=1, counter_iteration=0, round_valid=1, w=word 0 and k=K[0].
REQ-016 ROUND: in_ready=0; counter_iteration SHALL advance by 1 every cycle with no stall; w, k and counter_iteration are registered and mutually aligned.
REQ-017 For t<16, w = stored word t; for t>=16, w = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] mod 2^32, computed from a 16-word sliding window.
REQ-018 sigma0 = ROTR7 ^ ROTR18 ^ SHR3; sigma1 = ROTR17 ^ ROTR19 ^ SHR10; carries out of bit 31 are discarded.
REQ-019 k SHALL come from the 64-entry FIPS 180-4 constant table: K[0]=0x428a2f98, K[63]=0xc67178f2.
REQ-020 After t=63: one FINAL cycle with counter_iteration=64 and round_valid=0, then HOLD with counter_iteration=65.
REQ-021 HOLD: block_full=1, in_ready=0, and w and k hold their last values; next_block SHALL return the block to LOAD on the next cycle with counter_iteration=0, block_full=0, wr_cnt=0 and in_ready=1.
REQ-022 next_block SHALL be ignored in LOAD, ROUND and FINAL.
REQ-023 in_valid SHALL be ignored while in_ready=0; no word is lost or stored twice.
REQ-024 next_block and in_valid in the same HOLD cycle: the block transitions to LOAD and the word is not accepted.
REQ-025 Gaps in in_valid during LOAD SHALL preserve wr_cnt and the stored words.

Reset
REQ-026 While rst=0 at a clock edge: state=LOAD, wr_cnt=0, in_ready=0, w=0, k=0, counter_iteration=0, block_full=0, round_valid=0.
REQ-027 The first cycle after rst returns to 1 SHALL present in_ready=1.
REQ-028 Reset asserted mid-LOAD or mid-ROUND SHALL abort the operation, discard the partial block, and require a full 16-word reload.

Verification
REQ-029 Load the "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018) with no gaps -> block_full rises 1 cycle after word 15; w=0x61626380 at t=16 and w=0x000F0000 at t=17; k=0x428a2f98 at t=0 and k=0xc67178f2 at t=63.
REQ-030 Same block with random in_valid gaps -> the 64-word w stream is identical to the gap-free run; counter_iteration stays at 0 during LOAD.
REQ-031 Full round run -> round_valid is high for exactly 64 consecutive cycles; counter_iteration is 64 for 1 cycle, then 65 held; in_ready=0 throughout.
REQ-032 Pulse next_block during ROUND (t=30) -> no effect; pulse in HOLD together with in_valid=1 -> next cycle counter_iteration=0, block_full=0, in_ready=1, and the word is not stored.
REQ-033 Drive rst=0 at t=20, then reload the "abc" block -> all outputs reach their reset values at that edge, and the second run matches REQ-029 exactly.
REQ-034 Two back-to-back blocks separated by next_block -> the second block's W[16..63] match the reference model, with no carry-over from the first block's window.
